// File: rtl/hwpe_ctrl_job_dispatcher.sv
`default_nettype none
// ==== hwpe_ctrl_job_dispatcher == rev 1.0 ====================================
// Multi-core, multi-context HWPE job queue with owner-checked commits and per-core event routing.
module hwpe_ctrl_job_dispatcher #(
  parameter int N_CORES      = 8,
  parameter int N_CONTEXT    = 4,
  parameter int N_EVT        = 2,
  parameter int ID_WIDTH     = 16,
  parameter int DataWidth    = 32,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_req_i,
  output logic                         cfg_gnt_o,
  input  logic [31:0]                  cfg_add_i,
  input  logic                         cfg_wen_i,
  input  logic [DataWidth/8-1:0]       cfg_be_i,
  input  logic [DataWidth-1:0]         cfg_data_i,
  input  logic [ID_WIDTH-1:0]          cfg_id_i,
  output logic [DataWidth-1:0]         cfg_r_data_o,
  output logic                         cfg_r_valid_o,
  output logic [ID_WIDTH-1:0]          cfg_r_id_o,
  output logic                         start_o,
  output logic                         busy_o,
  output logic [$clog2(N_CONTEXT)-1:0] context_o,
  input  logic                         done_i,
  input  logic [N_EVT-2:0]             evt_i,
  output logic [N_CORES*N_EVT-1:0]     evt_o,
  output logic                         clear_o
);

  localparam int CW  = $clog2(N_CONTEXT);
  localparam int CIW = $clog2(N_CORES);
  localparam int PW  = CW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STARTING = 2'd1,
    RUN      = 2'd2
  } state_e;

  state_e           state;
  logic [CW-1:0]    head, tail;
  logic [PW-1:0]    pending, pending_nxt;
  logic             critical, triggered, triggered_nxt;
  logic [CIW-1:0]   owner, req_core, cur_core;
  logic [CIW-1:0]   slot_core [N_CONTEXT];
  logic [15:0]      finished;
  logic [N_CORES-1:0] mask;
  logic [3:0]       clr_cnt;

  logic             granted, wr, rd, acq_ok, commit_ok, done_acc, softclr, hold;
  logic [2:0]       word;
  logic [DataWidth-1:0] rdata;
  logic [N_CORES*N_EVT-1:0] evt_nxt;
  logic             unused_ok;

  assign unused_ok = ^{cfg_be_i, cfg_add_i[31:5], cfg_add_i[1:0], cfg_id_i};

  assign clear_o   = (clr_cnt != 4'd0);
  assign cfg_gnt_o = ~clear_o;
  assign granted   = cfg_req_i & cfg_gnt_o;
  assign word      = cfg_add_i[4:2];
  assign wr        = granted & ~cfg_wen_i;
  assign rd        = granted & cfg_wen_i;
  assign context_o = head;
  assign cur_core  = slot_core[head];

  // Lowest set bit of the one-hot ID names the requesting core
  always_comb begin
    req_core = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (cfg_id_i[i]) req_core = CIW'(i);
    end
  end

  assign acq_ok    = rd && (word == 3'd1) && !critical && (pending < PW'(N_CONTEXT));
  assign commit_ok = wr && (word == 3'd0) && critical && (req_core == owner);
  assign done_acc  = (state == RUN) && done_i;
  assign softclr   = wr && (word == 3'd5);
  assign hold      = clear_o | softclr;

  // A commit and a completion in the same cycle cancel out on the pending count
  always_comb begin
    pending_nxt = pending;
    case ({commit_ok, done_acc})
      2'b10:   pending_nxt = pending + PW'(1);
      2'b01:   pending_nxt = pending - PW'(1);
      default: pending_nxt = pending;
    endcase
    triggered_nxt = triggered;
    if (done_acc && (pending_nxt == '0)) triggered_nxt = 1'b0;
    if (commit_ok && (cfg_data_i == '0)) triggered_nxt = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (word)
      3'd1: begin
        if (acq_ok) rdata[CW-1:0] = tail;
        else        rdata = '1;
      end
      3'd2:    rdata[15:0] = finished;
      3'd3:    rdata[11:0] = {8'(pending), triggered, critical, state};
      3'd4:    rdata[N_CORES-1:0] = mask;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    evt_nxt = '0;
    for (int c = 0; c < N_CORES; c++) begin
      if ((cur_core == CIW'(c)) && !mask[c]) begin
        evt_nxt[c*N_EVT] = done_acc;
        if (state != IDLE) evt_nxt[c*N_EVT+1 +: N_EVT-1] = evt_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      start_o       <= 1'b0;
      busy_o        <= 1'b0;
      head          <= '0;
      tail          <= '0;
      pending       <= '0;
      critical      <= 1'b0;
      triggered     <= 1'b0;
      owner         <= '0;
      finished      <= '0;
      mask          <= '0;
      clr_cnt       <= '0;
      evt_o         <= '0;
      cfg_r_valid_o <= 1'b0;
      cfg_r_id_o    <= '0;
      cfg_r_data_o  <= '0;
      for (int s = 0; s < N_CONTEXT; s++) slot_core[s] <= '0;
    end else begin
      cfg_r_valid_o <= granted;
      cfg_r_id_o    <= granted ? cfg_id_i : '0;
      cfg_r_data_o  <= rd ? rdata : '0;

      if (softclr)         clr_cnt <= 4'(CLEAR_CYCLES);
      else if (clear_o)    clr_cnt <= clr_cnt - 4'd1;

      if (softclr && (cfg_data_i == '0))  mask <= '0;
      else if (wr && (word == 3'd4))      mask <= cfg_data_i[N_CORES-1:0];

      if (hold) begin
        state     <= IDLE;
        start_o   <= 1'b0;
        busy_o    <= 1'b0;
        head      <= '0;
        tail      <= '0;
        pending   <= '0;
        critical  <= 1'b0;
        triggered <= 1'b0;
        owner     <= '0;
        finished  <= '0;
        evt_o     <= '0;
      end else begin
        start_o   <= 1'b0;
        evt_o     <= evt_nxt;
        pending   <= pending_nxt;
        triggered <= triggered_nxt;
        if (acq_ok) begin
          critical <= 1'b1;
          owner    <= req_core;
        end
        if (commit_ok) begin
          slot_core[tail] <= owner;
          tail            <= tail + CW'(1);
          critical        <= 1'b0;
        end
        if (done_acc) begin
          head     <= head + CW'(1);
          finished <= finished + 16'd1;
        end
        // Look at next-cycle queue state so a triggering commit starts without an idle bubble
        case (state)
          IDLE: begin
            if ((pending_nxt != '0) && triggered_nxt) begin
              state  <= STARTING;
              busy_o <= 1'b1;
            end
          end
          STARTING: begin
            state   <= RUN;
            start_o <= 1'b1;
          end
          RUN: begin
            if (done_i) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
`default_nettype none
// ==== tb_hwpe_ctrl_job_dispatcher == rev 1.0 =================================
// Scoreboard bench: a queue-based job model predicts responses and per-cycle outputs.
module tb_hwpe_ctrl_job_dispatcher;

  localparam int N_CORES      = 8;
  localparam int N_CONTEXT    = 4;
  localparam int N_EVT        = 2;
  localparam int ID_WIDTH     = 16;
  localparam int DataWidth    = 32;
  localparam int CLEAR_CYCLES = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_req_i, cfg_gnt_o, cfg_wen_i, cfg_r_valid_o;
  logic [31:0] cfg_add_i, cfg_data_i, cfg_r_data_o;
  logic [3:0]  cfg_be_i;
  logic [15:0] cfg_id_i, cfg_r_id_o;
  logic        start_o, busy_o, done_i, clear_o;
  logic [1:0]  context_o;
  logic [0:0]  evt_i;
  logic [15:0] evt_o;

  hwpe_ctrl_job_dispatcher #(
    .N_CORES(N_CORES), .N_CONTEXT(N_CONTEXT), .N_EVT(N_EVT),
    .ID_WIDTH(ID_WIDTH), .DataWidth(DataWidth), .CLEAR_CYCLES(CLEAR_CYCLES)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_add_i(cfg_add_i),
    .cfg_wen_i(cfg_wen_i), .cfg_be_i(cfg_be_i), .cfg_data_i(cfg_data_i),
    .cfg_id_i(cfg_id_i), .cfg_r_data_o(cfg_r_data_o), .cfg_r_valid_o(cfg_r_valid_o),
    .cfg_r_id_o(cfg_r_id_o), .start_o(start_o), .busy_o(busy_o),
    .context_o(context_o), .done_i(done_i), .evt_i(evt_i), .evt_o(evt_o),
    .clear_o(clear_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [15:0] id; logic [31:0] data; } resp_t;
  typedef struct packed { logic start; logic busy; logic [1:0] ctx; logic clr; logic [15:0] evt; } cyc_t;

  resp_t resp_q[$];
  cyc_t  cyc_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: jobs are a queue of owner cores, front = running job
  int         m_jq[$];
  int         m_head = 0, m_tail = 0, m_owner = 0, m_fin = 0, m_phase = 0, m_clr = 0;
  bit         m_crit = 0, m_trig = 0;
  logic [7:0] m_mask = '0;

  task automatic model_step(input bit req, input bit wen, input int word, input logic [31:0] data,
                            input int core, input bit done, input logic ev);
    bit granted, rd, wr, acq_ok, commit, done_acc, softclr, hold;
    logic [31:0] rdv;
    resp_t r;
    cyc_t  c;
    granted = req && (m_clr == 0);
    rd      = granted && wen;
    wr      = granted && !wen;
    acq_ok  = rd && (word == 1) && !m_crit && (m_jq.size() < N_CONTEXT);
    rdv = '0;
    if (rd) begin
      case (word)
        1: rdv = acq_ok ? 32'(m_tail) : 32'hFFFF_FFFF;
        2: rdv = 32'(m_fin);
        3: rdv = {20'd0, 8'(m_jq.size()), m_trig, m_crit, 2'(m_phase)};
        4: rdv = 32'(m_mask);
        default: rdv = '0;
      endcase
    end
    if (granted) begin
      r.id = 16'(1) << core;
      r.data = rdv;
      resp_q.push_back(r);
    end
    softclr  = wr && (word == 5);
    hold     = (m_clr > 0) || softclr;
    done_acc = !hold && (m_phase == 2) && done;
    c.evt = '0;
    if (!hold && (m_phase != 0) && !m_mask[m_jq[0]]) begin
      c.evt[m_jq[0]*N_EVT]   = done_acc;
      c.evt[m_jq[0]*N_EVT+1] = ev;
    end
    if (softclr && (data == 0))    m_mask = '0;
    else if (wr && (word == 4))    m_mask = data[7:0];
    if (softclr)                   m_clr = CLEAR_CYCLES;
    else if (m_clr > 0)            m_clr--;
    if (hold) begin
      m_jq.delete();
      m_head = 0; m_tail = 0; m_crit = 0; m_trig = 0; m_fin = 0; m_phase = 0; m_owner = 0;
      c.start = 1'b0;
    end else begin
      c.start = (m_phase == 1);
      commit  = wr && (word == 0) && m_crit && (core == m_owner);
      if (acq_ok) begin m_crit = 1; m_owner = core; end
      if (commit) begin
        m_jq.push_back(m_owner);
        m_tail = (m_tail + 1) % N_CONTEXT;
        m_crit = 0;
        if (data == 0) m_trig = 1;
      end
      if (done_acc) begin
        m_jq.delete(0);
        m_head = (m_head + 1) % N_CONTEXT;
        m_fin  = (m_fin + 1) % 65536;
        if (m_jq.size() == 0) m_trig = 0;
      end
      case (m_phase)
        0: if (m_jq.size() > 0 && m_trig) m_phase = 1;
        1: m_phase = 2;
        default: if (done_acc) m_phase = 0;
      endcase
    end
    c.busy = (m_phase != 0);
    c.ctx  = 2'(m_head);
    c.clr  = (m_clr > 0);
    cyc_q.push_back(c);
  endtask

  task automatic tick(input bit req, input bit wen, input int word, input logic [31:0] data,
                      input int core, input bit done);
    logic [31:0] a;
    logic ev;
    @(negedge clk_i);
    a = $urandom;
    a[4:2] = 3'(word);
    ev = 1'($urandom);
    cfg_req_i = req; cfg_wen_i = wen; cfg_add_i = a; cfg_data_i = data;
    cfg_be_i = 4'($urandom); cfg_id_i = 16'(1) << core; done_i = done; evt_i = ev;
    checks++;
    if (cfg_gnt_o !== (m_clr == 0)) begin
      errors++;
      $display("FAIL gnt: got %b expected %b", cfg_gnt_o, (m_clr == 0));
    end
    model_step(req, wen, word, data, core, done, ev);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0, 0);
  endtask
  task automatic acq(input int core);                           tick(1, 1, 1, 0, core, 0); endtask
  task automatic commit(input int core, input logic [31:0] d);  tick(1, 0, 0, d, core, 0); endtask
  task automatic rdreg(input int w, input int core);            tick(1, 1, w, 0, core, 0); endtask
  task automatic wrreg(input int w, input logic [31:0] d, input int core); tick(1, 0, w, d, core, 0); endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (m_phase != 2 && n < 20) begin idle(1); n++; end
    if (m_phase != 2) begin
      errors++;
      $display("FAIL wait_run: engine not running after %0d cycles", n);
    end
  endtask

  task automatic finish_job();
    wait_run();
    tick(0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: responses whenever r_valid, per-cycle outputs whenever an expectation is queued
  initial begin
    resp_t r;
    cyc_t  c;
    forever begin
      @(posedge clk_i);
      #2;
      if (rst_ni) begin
        if (cfg_r_valid_o) begin
          checks++;
          if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_spurious: got id=%h data=%h, none expected", cfg_r_id_o, cfg_r_data_o);
          end else begin
            r = resp_q.pop_front();
            if (cfg_r_id_o !== r.id || cfg_r_data_o !== r.data) begin
              errors++;
              $display("FAIL rsp: got id=%h data=%h expected id=%h data=%h",
                       cfg_r_id_o, cfg_r_data_o, r.id, r.data);
            end
          end
        end
        if (cyc_q.size() > 0) begin
          c = cyc_q.pop_front();
          checks++;
          if ({start_o, busy_o, context_o, clear_o, evt_o} !== c) begin
            errors++;
            $display("FAIL outputs: got start=%b busy=%b ctx=%0d clr=%b evt=%h expected start=%b busy=%b ctx=%0d clr=%b evt=%h",
                     start_o, busy_o, context_o, clear_o, evt_o, c.start, c.busy, c.ctx, c.clr, c.evt);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int op, core, w;
    bit dn;
    logic [31:0] d;
    rst_ni = 1'b0;
    cfg_req_i = 0; cfg_wen_i = 0; cfg_add_i = '0; cfg_data_i = '0; cfg_be_i = '0;
    cfg_id_i = '0; done_i = 0; evt_i = '0;
    #17;
    checks++;
    if ({start_o, busy_o, context_o, clear_o, evt_o, cfg_r_valid_o, cfg_r_data_o, cfg_r_id_o} !== '0
        || cfg_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: start=%b busy=%b ctx=%0d clr=%b evt=%h rv=%b gnt=%b expected all 0, gnt=1",
               start_o, busy_o, context_o, clear_o, evt_o, cfg_r_valid_o, cfg_gnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single job from core 2
    acq(2); commit(2, 0); finish_job(); idle(2); rdreg(2, 2);
    // Fill the queue without triggering, overflow acquire, stray trigger, then recover
    for (int i = 0; i < 4; i++) begin acq(i + 3); commit(i + 3, 1); end
    acq(1); wrreg(0, 0, 1); idle(3); rdreg(3, 0);
    wrreg(5, 1, 0); idle(3);
    // Four jobs run in order
    for (int i = 0; i < 4; i++) begin acq(i); commit(i, (i == 3) ? 0 : 1); end
    for (int i = 0; i < 4; i++) finish_job();
    idle(2);
    // Non-owner commit is ignored
    acq(1); wrreg(0, 0, 3); rdreg(3, 3); commit(1, 1); rdreg(3, 1);
    wrreg(5, 0, 0); idle(3);
    // Commit and done in the same cycle
    acq(3); commit(3, 0); acq(4); commit(4, 1); acq(6); wait_run();
    tick(1, 0, 0, 1, 6, 1); rdreg(3, 6);
    finish_job(); finish_job(); idle(2);
    // Masked completion
    wrreg(4, 32'h4, 0); acq(2); commit(2, 0); finish_job(); idle(1); rdreg(2, 0);
    wrreg(4, 0, 0);
    // Soft clear while running keeps the mask
    wrreg(4, 32'h20, 0); acq(1); commit(1, 0); wait_run();
    wrreg(5, 1, 1); tick(1, 1, 3, 0, 2, 0); idle(2); rdreg(3, 1); rdreg(4, 1);
    wrreg(5, 0, 0); idle(3); rdreg(4, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      op   = $urandom_range(0, 99);
      core = $urandom_range(0, N_CORES - 1);
      dn   = ($urandom_range(0, 3) == 0);
      if (op < 25) tick(1, 1, 1, 0, core, dn);
      else if (op < 45) begin
        if ($urandom_range(0, 3) != 0) core = m_owner;
        d = ($urandom_range(0, 1) == 0) ? 32'd0 : ($urandom | 32'd1);
        tick(1, 0, 0, d, core, dn);
      end
      else if (op < 55) tick(1, 1, 3, 0, core, dn);
      else if (op < 62) tick(1, 1, 2, 0, core, dn);
      else if (op < 65) tick(1, 0, 4, 32'($urandom) & 32'($urandom) & 32'($urandom), core, dn);
      else if (op < 68) tick(1, 1, 4, 0, core, dn);
      else if (op < 69) tick(1, 0, 5, $urandom_range(0, 1), core, dn);
      else if (op < 73) begin
        w = $urandom_range(6, 7);
        tick(1, $urandom_range(0, 1), w, $urandom, core, dn);
      end
      else if (op < 76) begin
        w = ($urandom_range(0, 1) == 0) ? 0 : 5;
        tick(1, 1, w, 0, core, dn);
      end
      else tick(0, 0, 0, 0, core, dn);
    end
    idle(3);
    checks++;
    if (resp_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_missing: %0d responses outstanding, expected 0", resp_q.size());
    end

    // Asynchronous reset in the middle of a job
    wrreg(5, 0, 0); idle(3);
    acq(5); commit(5, 0); idle(3);
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({start_o, busy_o, context_o, clear_o, evt_o, cfg_r_valid_o} !== '0 || cfg_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: busy=%b start=%b ctx=%0d evt=%h rv=%b gnt=%b expected all 0, gnt=1",
               busy_o, start_o, context_o, evt_o, cfg_r_valid_o, cfg_gnt_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
